fft_ctrl64: RTL and testbench
=============================

# fft_ctrl64

Sequencer for the in-place radix-2 DIT FFT built around the single combinational `fft_core2` butterfly. On `start` it walks all FFT_PNT_WD stages × N/2 butterflies and drives everything the datapath needs:
- dual read addresses into the data RAM (bit-reversed input already loaded);
- the twiddle ROM index;
- the stage number;
- matching write-back addresses delayed by the read + butterfly pipeline latency.

It owns no data. It sits between the top-level FFT control and the RAM/ROM/core datapath.

## Interface
- FFT_PNT_WD, 6, log2 of FFT size N (64 points); supported 2..7
- PIPE_LAT, 2, cycles from `rd_en` to the matching write; minimum 1
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request to run one full FFT; sampled only in IDLE
- busy  out  1  high from the first RUN cycle through the DONE cycle
- done  out  1  one-cycle pulse when the last write-back has issued
- stage  out  3  current stage index s, 0..FFT_PNT_WD-1
- rd_en  out  1  butterfly operand read strobe
- rd_addr_1  out  FFT_PNT_WD  upper operand address (a)
- rd_addr_2  out  FFT_PNT_WD  lower operand address (b, multiplied by W)
- tw_addr  out  FFT_PNT_WD-1  twiddle ROM index k for W_N^k, valid with `rd_en`
- wr_en  out  1  write-back strobe, equal to `rd_en` delayed PIPE_LAT cycles
- wr_addr_1  out  FFT_PNT_WD  write address for core `dout_1` (= rd_addr_1 delayed)
- wr_addr_2  out  FFT_PNT_WD  write address for core `dout_2` (= rd_addr_2 delayed)

## Operation
- States:
  - IDLE → RUN when `start`=1.
  - RUN issues one butterfly per cycle, j = 0..N/2-1. RUN → WAIT after j = N/2-1.
  - WAIT holds for PIPE_LAT cycles.
    - WAIT → RUN with s+1 and j=0 if s < FFT_PNT_WD-1.
    - WAIT → DONE otherwise.
  - DONE lasts one cycle with `done`=1, then → IDLE.
- Address generation for stage s, butterfly j:
  - h = 2^s, pos = j mod h, grp = j >> s.
  - rd_addr_1 = grp·2h + pos.
  - rd_addr_2 = rd_addr_1 + h.
  - tw_addr = pos << (FFT_PNT_WD-1-s).
- All addresses are unsigned. There is no wrap-around: the maximum is N-1 and `tw_addr` stays below N/2.
- `stage` is valid with `rd_en`. It holds its value through WAIT and is 0 in IDLE.
- Write path:
  - A PIPE_LAT-deep shift register carries {rd_en, rd_addr_1, rd_addr_2} to {wr_en, wr_addr_1, wr_addr_2}.
  - The datapath supplies core outputs aligned to `wr_en`.
- Hazards: WAIT guarantees the last write of stage s happens before the first read of stage s+1. The RAM needs no same-cycle read-after-write bypass.
- `start` while busy (RUN/WAIT/DONE) is ignored and not queued.
- `rd_en` is low in IDLE, WAIT and DONE.
- Reset mid-operation:
  - State goes to IDLE and the counters clear.
  - The write shift register clears, so no `wr_en` is issued after reset.
  - Partial RAM contents are undefined.

## Timing
- Reset values: busy=0, done=0, stage=0, rd_en=0, rd_addr_1=0, rd_addr_2=0, tw_addr=0, wr_en=0, wr_addr_1=0, wr_addr_2=0.
- All outputs are registered; there are no combinational paths from `start` to the outputs.
- Cycle numbering: `start` is sampled high at edge 0.
  - Stage s reads on cycles 1 + s(N/2+PIPE_LAT) … s(N/2+PIPE_LAT) + N/2.
  - The last read of stage s is at cycle t; its write is at t+PIPE_LAT.
- `done` is high on cycle 1 + FFT_PNT_WD·(N/2+PIPE_LAT). For the defaults this is 205.
- `busy` is high on cycles 1..205 (defaults).
- A new `start` is accepted at the earliest on cycle 206, the first IDLE cycle.
- Per stage: exactly N/2 `rd_en` cycles and N/2 `wr_en` cycles.
  - Total `rd_en` cycles = total `wr_en` cycles = 192 (defaults).

## Test plan
- **Reset, then idle:** `rst`=1 for 2 cycles, then idle 10 cycles with `start`=0 → every output 0 throughout; no `wr_en`.
- **Stage 0:** `start` pulse → cycle 1 gives addrs 0/1, tw 0, stage 0; cycle 2 gives 2/3, tw 0; cycle 32 gives 62/63. `rd_en` is low on cycles 33–34.
- **Stage 2 and stage 5 addressing:**
  - Stage 2, j=5 (cycle 74) → addrs 9/13, tw 8, stage 2.
  - Stage 5, j=1 (cycle 172) → addrs 1/33, tw 1.
  - Stage 5, j=31 → addrs 31/63, tw 31.
- **Full-run count and write alignment:**
  - Count 192 `rd_en` and 192 `wr_en`.
  - Each `wr_addr` pair equals the `rd_addr` pair from 2 cycles earlier.
  - `done` is a single pulse on cycle 205; `busy` falls on cycle 206.
- **Start while busy:** assert `start` on cycles 50 and 205 → ignored; `done` still on 205 only. `start` on 206 → a new run begins with reads on 207.
- **Reset mid-run:** `rst` on cycle 100 → from cycle 101 all outputs are 0. No `wr_en` follows, even though reads were in flight. A new `start` then completes normally in 205 cycles.

Source files
------------

// File: rtl/fft_ctrl64.sv
// Sequences all stages and butterflies of an in-place radix-2 DIT FFT, producing read, twiddle and write-back addresses.
// Latency: reads begin 1 cycle after start; each write trails its read by PIPE_LAT cycles. There is no backpressure, and start is ignored while busy.
module fft_ctrl64 #(
  parameter int FFT_PNT_WD = 6,
  parameter int PIPE_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            stage,
  output logic                  rd_en,
  output logic [FFT_PNT_WD-1:0] rd_addr_1,
  output logic [FFT_PNT_WD-1:0] rd_addr_2,
  output logic [FFT_PNT_WD-2:0] tw_addr,
  output logic                  wr_en,
  output logic [FFT_PNT_WD-1:0] wr_addr_1,
  output logic [FFT_PNT_WD-1:0] wr_addr_2
);

  localparam int JW  = FFT_PNT_WD - 1;
  localparam int WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [2:0]      s_q, s_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;

  logic [FFT_PNT_WD-1:0] j_ext, h, pos, a1;
  logic [JW-1:0]         tw_c;

  logic [PIPE_LAT-1:0]   pe;
  logic [FFT_PNT_WD-1:0] pa1 [PIPE_LAT];
  logic [FFT_PNT_WD-1:0] pa2 [PIPE_LAT];

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          j_d     = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        if (j_q == {JW{1'b1}}) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      WAIT: begin
        // Drain the write pipe before the next stage reads what was just written.
        if (wcnt_q == WCW'(PIPE_LAT - 1)) begin
          j_d = '0;
          if (s_q == 3'(FFT_PNT_WD - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + 3'd1;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
        j_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses for the butterfly issued next cycle: a1 = grp*2h + pos, a2 = a1 + h.
  always_comb begin
    j_ext = {1'b0, j_d};
    h     = FFT_PNT_WD'(1) << s_d;
    pos   = j_ext & (h - FFT_PNT_WD'(1));
    a1    = ((j_ext >> s_d) << (s_d + 3'd1)) | pos;
    tw_c  = pos[JW-1:0] << (3'(JW) - s_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      j_q       <= '0;
      s_q       <= '0;
      wcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_1 <= '0;
      rd_addr_2 <= '0;
      tw_addr   <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      s_q       <= s_d;
      wcnt_q    <= wcnt_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      stage     <= s_d;
      rd_en     <= (state_d == RUN);
      rd_addr_1 <= (state_d == RUN) ? a1 : '0;
      rd_addr_2 <= (state_d == RUN) ? (a1 | h) : '0;
      tw_addr   <= (state_d == RUN) ? tw_c : '0;
    end
  end

  // Write-back pipe; clearing it on reset drops any in-flight writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pa1[i] <= '0;
        pa2[i] <= '0;
      end
    end else begin
      pe[0]  <= rd_en;
      pa1[0] <= rd_addr_1;
      pa2[0] <= rd_addr_2;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pe[i]  <= pe[i-1];
        pa1[i] <= pa1[i-1];
        pa2[i] <= pa2[i-1];
      end
    end
  end

  assign wr_en     = pe[PIPE_LAT-1];
  assign wr_addr_1 = pa1[PIPE_LAT-1];
  assign wr_addr_2 = pa2[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_ctrl64.sv
// Directed bench for fft_ctrl64 with default parameters (64 points, PIPE_LAT 2).
module tb_fft_ctrl64;

  localparam int W    = 6;
  localparam int LAT  = 2;
  localparam int HALF = 32;
  localparam int PER  = HALF + LAT;
  localparam int DONE_CYC = 1 + W * PER;

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy, done, rd_en, wr_en;
  logic [2:0]   stage;
  logic [W-1:0] rd_addr_1, rd_addr_2, wr_addr_1, wr_addr_2;
  logic [W-2:0] tw_addr;

  fft_ctrl64 #(.FFT_PNT_WD(W), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit rd;
    int st;
    int a1;
    int a2;
    int tw;
  } vec_t;

  vec_t vecs [9];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt, wr_cnt, done_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Expected read-side activity for a cycle numbered from the sampling of start.
  task automatic model(input int rel, output bit rd, output int st, output int a1,
                       output int a2, output int tw);
    int off, s, h;
    rd = 0; st = 0; a1 = 0; a2 = 0; tw = 0;
    if (rel >= 1 && rel <= DONE_CYC - 1) begin
      off = (rel - 1) % PER;
      s   = (rel - 1) / PER;
      st  = s;
      if (off < HALF) begin
        h  = 1 << s;
        rd = 1;
        a1 = (off / h) * 2 * h + off % h;
        a2 = a1 + h;
        tw = (off % h) * (HALF / h);
      end
    end
  endtask

  task automatic check_cycle(input int rel);
    bit rd, wrd;
    int st, a1, a2, tw, wst, w1, w2, wtw;
    model(rel, rd, st, a1, a2, tw);
    model(rel - LAT, wrd, wst, w1, w2, wtw);
    if (rd_en === 1'b1) rd_cnt++;
    if (wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
    chk("rd_en", 32'(rd_en), 32'(rd));
    if (rd) begin
      chk("stage", 32'(stage), st);
      chk("rd_addr_1", 32'(rd_addr_1), a1);
      chk("rd_addr_2", 32'(rd_addr_2), a2);
      chk("tw_addr", 32'(tw_addr), tw);
    end
    chk("busy", 32'(busy), 32'(rel >= 1 && rel <= DONE_CYC));
    chk("done", 32'(done), 32'(rel == DONE_CYC));
    chk("wr_en", 32'(wr_en), 32'(wrd));
    if (wrd) begin
      chk("wr_addr_1", 32'(wr_addr_1), w1);
      chk("wr_addr_2", 32'(wr_addr_2), w2);
    end
    if (rel <= 0 || rel > DONE_CYC) begin
      chk("idle_stage", 32'(stage), 0);
      chk("idle_rd_addr_1", 32'(rd_addr_1), 0);
      chk("idle_rd_addr_2", 32'(rd_addr_2), 0);
      chk("idle_tw_addr", 32'(tw_addr), 0);
      chk("idle_wr_addr_1", 32'(wr_addr_1), 0);
      chk("idle_wr_addr_2", 32'(wr_addr_2), 0);
    end
  endtask

  task automatic check_table(input int rel);
    for (int k = 0; k < 9; k++) begin
      if (vecs[k].cyc == rel) begin
        chk("vec_rd_en", 32'(rd_en), 32'(vecs[k].rd));
        if (vecs[k].rd) begin
          chk("vec_stage", 32'(stage), vecs[k].st);
          chk("vec_rd_addr_1", 32'(rd_addr_1), vecs[k].a1);
          chk("vec_rd_addr_2", 32'(rd_addr_2), vecs[k].a2);
          chk("vec_tw_addr", 32'(tw_addr), vecs[k].tw);
        end
      end
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_rd_count"}, rd_cnt, 192);
    chk({tag, "_wr_count"}, wr_cnt, 192);
    chk({tag, "_done_count"}, done_cnt, 1);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    vecs[0] = '{1,   1, 0, 0,  1,  0};
    vecs[1] = '{2,   1, 0, 2,  3,  0};
    vecs[2] = '{32,  1, 0, 62, 63, 0};
    vecs[3] = '{33,  0, 0, 0,  0,  0};
    vecs[4] = '{34,  0, 0, 0,  0,  0};
    vecs[5] = '{74,  1, 2, 9,  13, 8};
    vecs[6] = '{172, 1, 5, 1,  33, 1};
    vecs[7] = '{202, 1, 5, 31, 63, 31};
    vecs[8] = '{203, 0, 0, 0,  0,  0};

    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = -1;
    check_cycle(-1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_cycle(-1);
    end
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;

    // Run 1 with starts at 50 and 205 that must be ignored, then a restart at 206.
    start = 1'b1;
    tick();
    for (int c = 1; c <= 306; c++) begin
      int rel;
      rel = (c <= 206) ? c : c - 206;
      cyc = c;
      check_cycle(rel);
      if (c <= 206) check_table(rel);
      if (c == 206) check_counts("run1");
      start = (c == 50 || c == 205 || c == 206);
      if (c == 306) rst = 1'b1;
      tick();
    end

    // Reset arrived at cycle 100 of run 2: everything must read zero afterwards.
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc = 101 + i;
      chk("post_rst_wr_en", 32'(wr_en), 0);
      check_cycle(-1);
      tick();
    end
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int rel = 1; rel <= 206; rel++) begin
      cyc = rel;
      check_cycle(rel);
      tick();
    end
    check_counts("run3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
